// File: rtl/fu_issue_select.sv
// Per-FU oldest-first issue select: each free functional unit takes the oldest ready
// RS entry it can execute (age relative to rob_head) into a registered issue slot.
module fu_issue_select #(
    parameter int NUM_RS   = 4,
    parameter int NUM_FU   = 5,
    parameter int ROB_BITS = 4,
    parameter int XLEN     = 32,
    parameter int OP_W     = 4,
    parameter logic [2:0] BR_NB = 3'b000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [ROB_BITS-1:0]        rob_head,
    input  logic [NUM_RS-1:0]          rs_valid,
    input  logic [NUM_RS*NUM_FU-1:0]   rs_fu_mask,
    input  logic [NUM_RS*OP_W-1:0]     rs_op,
    input  logic [NUM_RS*XLEN-1:0]     rs_src1,
    input  logic [NUM_RS*XLEN-1:0]     rs_src2,
    input  logic [NUM_RS*ROB_BITS-1:0] rs_rob,
    input  logic [NUM_RS-1:0]          rs_load,
    input  logic [NUM_RS*3-1:0]        rs_branch,
    output logic [NUM_RS-1:0]          consumed,
    input  logic [NUM_FU-1:0]          fu_ready,
    output logic [NUM_FU-1:0]          iss_valid,
    output logic [NUM_FU*XLEN-1:0]     iss_src1,
    output logic [NUM_FU*XLEN-1:0]     iss_src2,
    output logic [NUM_FU*OP_W-1:0]     iss_op,
    output logic [NUM_FU*ROB_BITS-1:0] iss_rob,
    output logic [NUM_FU-1:0]          iss_load,
    output logic [NUM_FU*3-1:0]        iss_branch
);
    localparam int IDX_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

    // Handshake: slot k transfers to its FU on any cycle with iss_valid[k] && fu_ready[k];
    // the slot is free to capture when it is empty or transferring this cycle.
    logic [NUM_FU-1:0]   fu_free;
    logic [NUM_FU-1:0]   grant_vld;
    logic [IDX_W-1:0]    grant_idx [NUM_FU];
    logic [NUM_RS-1:0]   taken;
    logic [ROB_BITS-1:0] age [NUM_RS];

    assign fu_free  = ~iss_valid | fu_ready;
    assign consumed = taken;

    // Modular distance from the ROB head; smaller means older.
    always_comb begin
        for (int i = 0; i < NUM_RS; i++) begin
            age[i] = rs_rob[i*ROB_BITS +: ROB_BITS] - rob_head;
        end
    end

    always_comb begin : alloc
        logic                found;
        logic [ROB_BITS-1:0] best_age;
        logic [IDX_W-1:0]    best;
        taken     = '0;
        grant_vld = '0;
        found     = 1'b0;
        best_age  = '0;
        best      = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            grant_idx[k] = '0;
            found        = 1'b0;
            best_age     = '0;
            best         = '0;
            // Strict compare keeps the lower RS index on an age tie.
            for (int i = 0; i < NUM_RS; i++) begin
                if (rs_valid[i] && rs_fu_mask[i*NUM_FU + k] && !taken[i] &&
                    (!found || (age[i] < best_age))) begin
                    found    = 1'b1;
                    best_age = age[i];
                    best     = IDX_W'(i);
                end
            end
            if (found && fu_free[k] && !flush && !reset) begin
                grant_vld[k]  = 1'b1;
                grant_idx[k]  = best;
                taken[best]   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            iss_valid  <= '0;
            iss_src1   <= '0;
            iss_src2   <= '0;
            iss_op     <= '0;
            iss_rob    <= '0;
            iss_load   <= '0;
            iss_branch <= {NUM_FU{BR_NB}};
        end else begin
            for (int k = 0; k < NUM_FU; k++) begin
                if (flush) begin
                    iss_valid[k] <= 1'b0;
                end else if (grant_vld[k]) begin
                    iss_valid[k]                   <= 1'b1;
                    iss_src1[k*XLEN +: XLEN]       <= rs_src1[grant_idx[k]*XLEN +: XLEN];
                    iss_src2[k*XLEN +: XLEN]       <= rs_src2[grant_idx[k]*XLEN +: XLEN];
                    iss_op[k*OP_W +: OP_W]         <= rs_op[grant_idx[k]*OP_W +: OP_W];
                    iss_rob[k*ROB_BITS +: ROB_BITS] <= rs_rob[grant_idx[k]*ROB_BITS +: ROB_BITS];
                    iss_load[k]                    <= rs_load[grant_idx[k]];
                    iss_branch[k*3 +: 3]           <= rs_branch[grant_idx[k]*3 +: 3];
                end else if (fu_ready[k]) begin
                    iss_valid[k] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_fu_issue_select.sv
// Directed and randomised stimulus for fu_issue_select with an expected-result queue
// of per-FU issue-register contents, drained right after each capturing edge.
module tb_fu_issue_select;
    localparam int NUM_RS   = 4;
    localparam int NUM_FU   = 5;
    localparam int ROB_BITS = 4;
    localparam int XLEN     = 32;
    localparam int OP_W     = 4;
    localparam logic [2:0] BR_NB = 3'b000;
    localparam int REC_W = 1 + 2*XLEN + OP_W + ROB_BITS + 1 + 3;
    localparam int Q_W   = REC_W + 4;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       flush;
    logic [ROB_BITS-1:0]        rob_head;
    logic [NUM_RS-1:0]          rs_valid;
    logic [NUM_RS*NUM_FU-1:0]   rs_fu_mask;
    logic [NUM_RS*OP_W-1:0]     rs_op;
    logic [NUM_RS*XLEN-1:0]     rs_src1;
    logic [NUM_RS*XLEN-1:0]     rs_src2;
    logic [NUM_RS*ROB_BITS-1:0] rs_rob;
    logic [NUM_RS-1:0]          rs_load;
    logic [NUM_RS*3-1:0]        rs_branch;
    logic [NUM_RS-1:0]          consumed;
    logic [NUM_FU-1:0]          fu_ready;
    logic [NUM_FU-1:0]          iss_valid;
    logic [NUM_FU*XLEN-1:0]     iss_src1;
    logic [NUM_FU*XLEN-1:0]     iss_src2;
    logic [NUM_FU*OP_W-1:0]     iss_op;
    logic [NUM_FU*ROB_BITS-1:0] iss_rob;
    logic [NUM_FU-1:0]          iss_load;
    logic [NUM_FU*3-1:0]        iss_branch;

    logic [Q_W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    fu_issue_select #(
        .NUM_RS(NUM_RS), .NUM_FU(NUM_FU), .ROB_BITS(ROB_BITS),
        .XLEN(XLEN), .OP_W(OP_W), .BR_NB(BR_NB)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush), .rob_head(rob_head),
        .rs_valid(rs_valid), .rs_fu_mask(rs_fu_mask), .rs_op(rs_op),
        .rs_src1(rs_src1), .rs_src2(rs_src2), .rs_rob(rs_rob),
        .rs_load(rs_load), .rs_branch(rs_branch), .consumed(consumed),
        .fu_ready(fu_ready), .iss_valid(iss_valid), .iss_src1(iss_src1),
        .iss_src2(iss_src2), .iss_op(iss_op), .iss_rob(iss_rob),
        .iss_load(iss_load), .iss_branch(iss_branch)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [REC_W-1:0] dut_rec(input int k);
        return {iss_valid[k], iss_src1[k*XLEN +: XLEN], iss_src2[k*XLEN +: XLEN],
                iss_op[k*OP_W +: OP_W], iss_rob[k*ROB_BITS +: ROB_BITS],
                iss_load[k], iss_branch[k*3 +: 3]};
    endfunction

    // Expected slot contents built from the stimulus the bench itself drove.
    function automatic logic [REC_W-1:0] rs_rec(input int i);
        return {1'b1, rs_src1[i*XLEN +: XLEN], rs_src2[i*XLEN +: XLEN],
                rs_op[i*OP_W +: OP_W], rs_rob[i*ROB_BITS +: ROB_BITS],
                rs_load[i], rs_branch[i*3 +: 3]};
    endfunction

    // driver tasks
    task automatic clear_rs();
        rs_valid   = '0;
        rs_fu_mask = '0;
        rs_op      = '0;
        rs_src1    = '0;
        rs_src2    = '0;
        rs_rob     = '0;
        rs_load    = '0;
        rs_branch  = '0;
    endtask

    task automatic set_entry(input int i, input logic [NUM_FU-1:0] mask, input logic [ROB_BITS-1:0] rob);
        rs_valid[i]                   = 1'b1;
        rs_fu_mask[i*NUM_FU +: NUM_FU] = mask;
        rs_rob[i*ROB_BITS +: ROB_BITS] = rob;
        rs_op[i*OP_W +: OP_W]         = OP_W'($urandom_range(0, 15));
        rs_src1[i*XLEN +: XLEN]       = $urandom;
        rs_src2[i*XLEN +: XLEN]       = $urandom;
        rs_load[i]                    = 1'($urandom_range(0, 1));
        rs_branch[i*3 +: 3]           = 3'($urandom_range(0, 7));
    endtask

    task automatic push_full(input int k, input logic [REC_W-1:0] rec);
        exp_q.push_back({1'b0, 3'(k), rec});
    endtask

    task automatic push_idle_except(input logic [NUM_FU-1:0] busy);
        for (int k = 0; k < NUM_FU; k++) begin
            if (!busy[k]) exp_q.push_back({1'b1, 3'(k), {REC_W{1'b0}}});
        end
    endtask

    // scoreboard: consumed checked mid-cycle, queued slot expectations drained after the edge
    task automatic step(input string tag, input logic [NUM_RS-1:0] exp_cons);
        logic [Q_W-1:0]   e;
        logic [REC_W-1:0] got;
        int               k;
        @(negedge clk);
        check({tag, ".consumed"}, 128'(consumed), 128'(exp_cons));
        @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            k   = int'(e[REC_W +: 3]);
            got = dut_rec(k);
            if (e[Q_W-1]) check($sformatf("%s.valid%0d", tag, k), 128'(got[REC_W-1]), 128'(1'b0));
            else          check($sformatf("%s.slot%0d", tag, k), 128'(got), 128'(e[REC_W-1:0]));
        end
    endtask

    initial begin
        logic [REC_W-1:0]  held;
        logic [NUM_FU-1:0] mask;
        int                fu;

        reset    = 1'b1;
        flush    = 1'b0;
        rob_head = '0;
        fu_ready = '0;
        clear_rs();
        for (int i = 0; i < NUM_RS; i++) set_entry(i, '1, ROB_BITS'(i));

        // reset held two cycles with everything ready
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < NUM_FU; k++) push_full(k, {{(REC_W-3){1'b0}}, BR_NB});
            step("reset", 4'b0000);
        end
        reset = 1'b0;
        clear_rs();
        push_idle_except('0);
        step("post_reset", 4'b0000);

        // age priority across ROB wrap: ROB 15 older than ROB 1 with head 14
        fu_ready = '1;
        rob_head = 4'd14;
        set_entry(0, 5'b00001, 4'd1);
        set_entry(2, 5'b00001, 4'd15);
        push_full(0, rs_rec(2));
        push_idle_except(5'b00001);
        step("wrap", 4'b0100);

        // two entries eligible on FU0 and FU1: oldest to FU0, next to FU1
        clear_rs();
        set_entry(1, 5'b00011, 4'd0);
        set_entry(3, 5'b00011, 4'd3);
        push_full(0, rs_rec(1));
        push_full(1, rs_rec(3));
        push_idle_except(5'b00011);
        step("dual", 4'b1010);

        // back-pressure on FU2
        clear_rs();
        rob_head = 4'd0;
        set_entry(0, 5'b00100, 4'd4);
        held = rs_rec(0);
        push_full(2, held);
        push_idle_except(5'b00100);
        step("mul_issue", 4'b0001);
        clear_rs();
        set_entry(1, 5'b00100, 4'd5);
        fu_ready = 5'b11011;
        for (int c = 0; c < 3; c++) begin
            push_full(2, held);
            push_idle_except(5'b00100);
            step("mul_hold", 4'b0000);
        end
        fu_ready = '1;
        push_full(2, rs_rec(1));
        push_idle_except(5'b00100);
        step("mul_release", 4'b0010);
        clear_rs();
        push_idle_except('0);
        step("mul_drain", 4'b0000);

        // flush drops a held instruction and blocks capture
        set_entry(0, 5'b01000, 4'd6);
        fu_ready = 5'b10111;
        push_full(3, rs_rec(0));
        push_idle_except(5'b01000);
        step("pre_flush", 4'b0001);
        clear_rs();
        set_entry(1, '1, 4'd7);
        flush = 1'b1;
        push_idle_except('0);
        step("flush", 4'b0000);
        flush    = 1'b0;
        fu_ready = '1;
        clear_rs();
        push_idle_except('0);
        step("post_flush", 4'b0000);

        // unmapped entry sits valid while a mapped entry keeps issuing
        for (int c = 0; c < 10; c++) begin
            clear_rs();
            rob_head = ROB_BITS'($urandom_range(0, 15));
            set_entry(3, '0, ROB_BITS'($urandom_range(0, 15)));
            mask = NUM_FU'($urandom_range(1, 31));
            set_entry(0, mask, ROB_BITS'($urandom_range(0, 15)));
            fu = 0;
            while (!mask[fu]) fu++;
            push_full(fu, rs_rec(0));
            push_idle_except(NUM_FU'(1) << fu);
            step("unmapped", 4'b0001);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
